// File: rtl/count_event_logger_if.sv
// Output handshake bundle for count_event_logger: the head-of-FIFO event entry
// together with its valid/ready pair.
interface count_event_logger_if;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/count_event_logger.sv
// Watches an upstream 8-bit counter, turns wrap / threshold / counter-reset
// transitions into 16-bit event entries and queues them in a small FIFO.
module count_event_logger #(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  count_in,
    input  logic                        enable_in,
    input  logic [7:0]                  threshold,
    input  logic                        thr_en,
    input  logic                        clr_ovf,
    count_event_logger_if.master        out_if,
    output logic                        fifo_full,
    output logic                        overflow,
    output logic [7:0]                  drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_OCC = (PW + 1)'(DEPTH);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
    endfunction

    logic [7:0]    prev_count_r;
    logic          prev_valid_r;
    logic [4:0]    wrap_cnt_r;
    logic [15:0]   mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW:0]   occ_r;
    logic          overflow_r;
    logic [7:0]    drop_cnt_r;

    logic          wrap_s;
    logic          thr_s;
    logic          crst_s;
    logic          hold_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          push_ok_s;
    logic          drop_s;
    logic [4:0]    wrap_next_s;
    logic [15:0]   entry_s;

    // A stopped counter holding its value can never produce an event.
    assign hold_s = (~enable_in) & (count_in == prev_count_r);

    assign wrap_s = prev_valid_r & (prev_count_r == 8'hFF) & (count_in == 8'h00);
    assign thr_s  = prev_valid_r & thr_en & (count_in == threshold) & (prev_count_r != threshold);
    assign crst_s = prev_valid_r & (count_in == 8'h00) & (prev_count_r != 8'h00)
                  & (prev_count_r != 8'hFF);

    assign push_s    = (wrap_s | thr_s | crst_s) & ~hold_s;
    assign full_s    = (occ_r == FULL_OCC);
    assign pop_s     = (occ_r != '0) & out_if.out_ready;
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign drop_s    = push_s & full_s & ~pop_s;

    // Next wrap count: counter reset takes priority, then wrap increments.
    always_comb begin
        wrap_next_s = wrap_cnt_r;
        if (crst_s) begin
            wrap_next_s = 5'd0;
        end else if (wrap_s) begin
            wrap_next_s = wrap_cnt_r + 5'd1;
        end else begin
            wrap_next_s = wrap_cnt_r;
        end
    end

    assign entry_s = {crst_s, thr_s, wrap_s, wrap_next_s, count_in};

    // Previous-sample tracking and wrap counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_count_r <= 8'd0;
            prev_valid_r <= 1'b0;
            wrap_cnt_r   <= 5'd0;
        end else begin
            prev_count_r <= count_in;
            prev_valid_r <= 1'b1;
            wrap_cnt_r   <= wrap_next_s;
        end
    end

    // Event FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 16'd0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= entry_s;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   occ_r <= occ_r + (PW + 1)'(1);
                2'b01:   occ_r <= occ_r - (PW + 1)'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Sticky overflow and drop counter; a drop beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= clr_ovf ? 8'd1 : sat_inc8(drop_cnt_r);
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else begin
            overflow_r <= overflow_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign out_if.out_valid = (occ_r != '0);
    assign out_if.out_data  = mem_r[rd_ptr_r];
    assign fifo_full        = full_s;
    assign overflow         = overflow_r;
    assign drop_cnt         = drop_cnt_r;

endmodule
